// File: rtl/vram_wr_arb.sv
// Two-requester round-robin arbiter and full-frame clear sequencer for the VRAM write port.
// Latency: a transfer accepted at edge N is on vram_* after edge N; one write per cycle.
// Backpressure: r0_ready/r1_ready go high combinationally for the winner only, both low while clearing.
//
// Ports: CLOCK_50 / reset (synchronous, active-low); r0_* renderer and r1_* host
// valid/adr/d in with ready out; clr_start/clr_color start a fill and clr_busy
// reports it; vram_we/vram_wadr/vram_d drive the VRAM write port; last_gnt is the
// index of the most recently granted requester.
// Optional feature: define VRAM_WR_ARB_CLEAR_EN to build in the clear engine;
// without it clr_start/clr_color are ignored and clr_busy is tied to 0.
module vram_wr_arb #(
    parameter int DW     = 24,
    parameter int AW     = 16,
    parameter int PIXELS = 53760
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          r0_valid,
    input  logic [AW-1:0] r0_adr,
    input  logic [DW-1:0] r0_d,
    output logic          r0_ready,
    input  logic          r1_valid,
    input  logic [AW-1:0] r1_adr,
    input  logic [DW-1:0] r1_d,
    output logic          r1_ready,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          clr_busy,
    output logic          vram_we,
    output logic [AW-1:0] vram_wadr,
    output logic [DW-1:0] vram_d,
    output logic          last_gnt
);

    logic          we_n;
    logic [AW-1:0] wadr_n;
    logic [DW-1:0] d_n;
    logic          last_n;

`ifdef VRAM_WR_ARB_CLEAR_EN
    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [AW-1:0] LAST_ADR = AW'(PIXELS - 1);

    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [DW-1:0] color, color_n;

    assign clr_busy = (state == CLEAR);
`else
    assign clr_busy = 1'b0;

    logic unused_clr;
    assign unused_clr = ^{clr_start, clr_color};
`endif

    always_comb begin
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        we_n     = 1'b0;
        wadr_n   = vram_wadr;
        d_n      = vram_d;
        last_n   = last_gnt;
`ifdef VRAM_WR_ARB_CLEAR_EN
        state_n  = state;
        cnt_n    = cnt;
        color_n  = color;
        if (state == CLEAR) begin
            we_n   = 1'b1;
            wadr_n = cnt;
            d_n    = color;
            // The counter stops at the last address instead of wrapping.
            if (cnt == LAST_ADR) begin
                state_n = ARB;
            end else begin
                cnt_n = cnt + AW'(1);
            end
        end else if (clr_start) begin
            // Clear wins over any pending request in the start cycle too.
            state_n = CLEAR;
            cnt_n   = '0;
            color_n = clr_color;
        end else
`endif
        begin
            // Ready is gated by reset so nothing is acknowledged while in reset.
            if (reset) begin
                if (r0_valid && (!r1_valid || last_gnt)) begin
                    r0_ready = 1'b1;
                end else if (r1_valid) begin
                    r1_ready = 1'b1;
                end
            end
            if (r0_ready) begin
                we_n   = 1'b1;
                wadr_n = r0_adr;
                d_n    = r0_d;
                last_n = 1'b0;
            end else if (r1_ready) begin
                we_n   = 1'b1;
                wadr_n = r1_adr;
                d_n    = r1_d;
                last_n = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            vram_we   <= 1'b0;
            vram_wadr <= '0;
            vram_d    <= '0;
            last_gnt  <= 1'b1;
`ifdef VRAM_WR_ARB_CLEAR_EN
            state     <= ARB;
            cnt       <= '0;
            color     <= '0;
`endif
        end else begin
            vram_we   <= we_n;
            vram_wadr <= wadr_n;
            vram_d    <= d_n;
            last_gnt  <= last_n;
`ifdef VRAM_WR_ARB_CLEAR_EN
            state     <= state_n;
            cnt       <= cnt_n;
            color     <= color_n;
`endif
        end
    end

endmodule
